// File: rtl/vga_timing_monitor.sv
// Passive checker behind the VGA controller: rebuilds pixel coordinates from hsync/vsync,
// verifies 640x480@60 line/frame timing and streams visible pixels with a valid strobe.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT       = 480
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        h_err,
  output logic        v_err,
  output logic        rgb_err
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [9:0] CNT_MAX  = 10'd1023;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] H_FIRST  = 10'(H_ACT_START);
  localparam logic [9:0] H_END    = 10'(H_ACT_START + H_ACT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] V_FIRST  = 10'(V_ACT_START);
  localparam logic [9:0] V_END    = 10'(V_ACT_START + V_ACT - 1);

  logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [15:0] rgb_q;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]  state_q, state_d;
  logic        pix_valid_q, locked_q, frame_done_q, h_err_q, v_err_q, rgb_err_q;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_rgb_q, pix_rgb_d, frame_cnt_q;

  logic hs_rise_s, hs_fall_s, vs_rise_s, vs_fall_s;
  logic checking_s, h_bad_s, v_bad_s, visible_s, pv_s, fd_s, rgb_bad_s;

  assign hs_rise_s = hs_q & ~hs_prev_q;
  assign hs_fall_s = ~hs_q & hs_prev_q;
  assign vs_rise_s = vs_q & ~vs_prev_q;
  assign vs_fall_s = ~vs_q & vs_prev_q;

  always_comb begin
    h_cnt_d = h_cnt_q;
    if (hs_rise_s) begin
      h_cnt_d = 10'd0;
    end else if (h_cnt_q != CNT_MAX) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end else begin
      h_cnt_d = h_cnt_q;
    end
  end

  always_comb begin
    v_cnt_d = v_cnt_q;
    if (vs_rise_s) begin
      v_cnt_d = 10'd0;
    end else if (hs_rise_s && (v_cnt_q != CNT_MAX)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  // Rising edges judge the period just ended (old count); falling edges judge the
  // pulse width, i.e. the count the falling sample itself carries.
  assign checking_s = (state_q == ST_CHECK) || (state_q == ST_LOCKED);
  assign h_bad_s = checking_s &&
                   ((hs_rise_s && (h_cnt_q != H_LAST)) ||
                    (hs_fall_s && (h_cnt_d != H_SYNC_W)) ||
                    ((h_cnt_q != CNT_MAX) && (h_cnt_d == CNT_MAX)));
  assign v_bad_s = checking_s &&
                   ((vs_rise_s && (v_cnt_q != V_LAST)) ||
                    (vs_fall_s && (v_cnt_d != V_SYNC_W)));

  assign visible_s = (h_cnt_d >= H_FIRST) && (h_cnt_d <= H_END) &&
                     (v_cnt_d >= V_FIRST) && (v_cnt_d <= V_END);
  assign pv_s      = (state_q == ST_LOCKED) && visible_s;
  assign rgb_bad_s = (state_q == ST_LOCKED) && !visible_s && (rgb_q != 16'h0000);
  assign fd_s      = (state_q == ST_LOCKED) && vs_rise_s && !h_bad_s && !v_bad_s;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_rise_s) state_d = ST_CHECK;
        else           state_d = ST_SEARCH;
      end
      ST_CHECK: begin
        if (h_bad_s || v_bad_s) state_d = ST_SEARCH;
        else if (vs_rise_s)     state_d = ST_LOCKED;
        else                    state_d = ST_CHECK;
      end
      ST_LOCKED: begin
        if (h_bad_s || v_bad_s) state_d = ST_SEARCH;
        else                    state_d = ST_LOCKED;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    pix_rgb_d = pix_rgb_q;
    if (pv_s) begin
      pix_x_d   = h_cnt_d - H_FIRST;
      pix_y_d   = v_cnt_d - V_FIRST;
      pix_rgb_d = rgb_q;
    end else begin
      pix_x_d   = pix_x_q;
      pix_y_d   = pix_y_q;
      pix_rgb_d = pix_rgb_q;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      hs_q <= 1'b0; vs_q <= 1'b0; hs_prev_q <= 1'b0; vs_prev_q <= 1'b0;
      rgb_q <= 16'h0000;
      h_cnt_q <= 10'd0; v_cnt_q <= 10'd0;
      state_q <= ST_SEARCH;
      pix_valid_q <= 1'b0; pix_x_q <= 10'd0; pix_y_q <= 10'd0; pix_rgb_q <= 16'h0000;
      locked_q <= 1'b0; frame_done_q <= 1'b0; frame_cnt_q <= 16'h0000;
      h_err_q <= 1'b0; v_err_q <= 1'b0; rgb_err_q <= 1'b0;
    end else begin
      hs_q <= hsync; vs_q <= vsync; hs_prev_q <= hs_q; vs_prev_q <= vs_q;
      rgb_q <= rgb;
      h_cnt_q <= h_cnt_d; v_cnt_q <= v_cnt_d;
      state_q <= state_d;
      pix_valid_q <= pv_s; pix_x_q <= pix_x_d; pix_y_q <= pix_y_d; pix_rgb_q <= pix_rgb_d;
      locked_q <= (state_d == ST_LOCKED);
      frame_done_q <= fd_s;
      frame_cnt_q <= fd_s ? frame_cnt_q + 16'd1 : frame_cnt_q;
      h_err_q <= h_bad_s; v_err_q <= v_bad_s; rgb_err_q <= rgb_bad_s;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign h_err      = h_err_q;
  assign v_err      = v_err_q;
  assign rgb_err    = rgb_err_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down video mode (40x20 total,
// 24x12 visible) so whole frames stay short; the h_cnt timeout still spans 1023 clocks.
module tb_vga_timing_monitor;
  localparam int HT = 40, HS = 4, HAS = 8, HA = 24;
  localparam int VT = 20, VS = 2, VAS = 4, VA = 12;

  logic        vga_clk = 1'b0;
  logic        sys_rst, hsync, vsync;
  logic [15:0] rgb;
  logic        pix_valid, locked, frame_done, h_err, v_err, rgb_err;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_rgb, frame_cnt;

  always #20 vga_clk = ~vga_clk;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT(VA)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .locked(locked), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .h_err(h_err), .v_err(v_err), .rgb_err(rgb_err)
  );

  int n_vec = 0, n_miss = 0;
  int cyc = 0;
  int line_cyc [VT];
  int inj_line = -1, inj_col = -1, first_idx = -1;

  // Output monitor: counters and timestamps of events, sampled on the falling edge.
  int pix_total = 0, herr_n = 0, verr_n = 0, rerr_n = 0;
  int herr_cyc = 0, verr_cyc = 0, lock_rise_cyc = 0, lock_fall_cyc = 0, first_cyc = 0;
  logic [9:0]  first_x = 10'd0, first_y = 10'd0, last_x = 10'd0, last_y = 10'd0;
  logic [15:0] first_rgb = 16'h0000, last_rgb = 16'h0000;
  logic        lock_prev = 1'b0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  always @(negedge vga_clk) begin
    lock_prev <= locked;
    if (locked && !lock_prev) lock_rise_cyc <= cyc;
    if (!locked && lock_prev) lock_fall_cyc <= cyc;
    if (pix_valid) begin
      pix_total <= pix_total + 1;
      last_x <= pix_x; last_y <= pix_y; last_rgb <= pix_rgb;
      if (pix_total == first_idx) begin
        first_x <= pix_x; first_y <= pix_y; first_rgb <= pix_rgb; first_cyc <= cyc;
      end
    end
    if (h_err) begin herr_n <= herr_n + 1; herr_cyc <= cyc; end
    if (v_err) begin verr_n <= verr_n + 1; verr_cyc <= cyc; end
    if (rgb_err) rerr_n <= rerr_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [15:0] bar(input int col);
    case (col / 3)
      0: bar = 16'hFFFF;
      1: bar = 16'hFFE0;
      2: bar = 16'h07FF;
      3: bar = 16'h07E0;
      4: bar = 16'hF81F;
      5: bar = 16'hF800;
      6: bar = 16'h001F;
      7: bar = 16'h0841;
      default: bar = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] pix_of(input int ln, input int c);
    logic [15:0] v;
    v = 16'h0000;
    if (ln >= VAS && ln < VAS + VA && c >= HAS && c < HAS + HA) v = bar(c - HAS);
    if (ln == inj_line && c == inj_col) v = 16'hF800;
    return v;
  endfunction

  task automatic tick(input logic h, input logic v, input logic [15:0] c, input logic r);
    hsync = h; vsync = v; rgb = c; sys_rst = r;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic send_cols(input int ln, input int c0, input int c1, input int vs_w);
    for (int c = c0; c < c1; c++) begin
      if (c == 0) line_cyc[ln] = cyc;
      tick(c < HS, ln < vs_w, pix_of(ln, c), 1'b0);
    end
  endtask

  task automatic send_frame(input int vs_w, input int short_ln);
    for (int ln = 0; ln < VT; ln++) send_cols(ln, 0, (ln == short_ln) ? HT - 1 : HT, vs_w);
  endtask

  int p0, mark;

  initial begin
    sys_rst = 1'b1; hsync = 1'b0; vsync = 1'b0; rgb = 16'h0000;
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b0);

    // Nominal stream: lock on the second vsync edge, full visible frame afterwards.
    send_frame(VS, -1);
    chk("f1_not_locked", locked, 0);
    send_frame(VS, -1);
    chk("f2_locked", locked, 1);
    chk("f2_lock_rise_cyc", lock_rise_cyc, line_cyc[0] + 2);
    chk("f2_no_fd_on_lock", frame_cnt, 0);
    p0 = pix_total; first_idx = pix_total;
    send_frame(VS, -1);
    chk("f3_pix_count", pix_total - p0, 288);
    chk("f3_first_x", first_x, 0);
    chk("f3_first_y", first_y, 0);
    chk("f3_first_rgb", first_rgb, 16'hFFFF);
    chk("f3_first_latency", first_cyc, line_cyc[VAS] + HAS + 2);
    chk("f3_last_x", last_x, 23);
    chk("f3_last_y", last_y, 11);
    chk("f3_last_rgb", last_rgb, 16'h0841);
    chk("f3_hold_x", pix_x, 23);
    chk("f3_frame_cnt", frame_cnt, 1);
    chk("f3_no_errs", herr_n + verr_n + rerr_n, 0);

    // Colour in horizontal blanking while locked.
    inj_line = 5; inj_col = 2; p0 = pix_total;
    send_frame(VS, -1);
    inj_line = -1; inj_col = -1;
    chk("rgb_err_count", rerr_n, 1);
    chk("rgb_err_locked", locked, 1);
    chk("rgb_err_pix_count", pix_total - p0, 288);
    chk("rgb_err_frame_cnt", frame_cnt, 2);

    // Line 7 one clock short.
    send_frame(VS, 7);
    chk("short_herr_count", herr_n, 1);
    chk("short_herr_cyc", herr_cyc, line_cyc[8] + 2);
    chk("short_lock_fall_cyc", lock_fall_cyc, line_cyc[8] + 2);
    chk("short_frame_cnt", frame_cnt, 3);
    send_frame(VS, -1);
    chk("relock1_not_locked", locked, 0);
    send_frame(VS, -1);
    chk("relock2_locked", locked, 1);
    chk("relock2_frame_cnt", frame_cnt, 3);

    // vsync three lines wide.
    send_frame(3, -1);
    chk("vwide_verr_count", verr_n, 1);
    chk("vwide_verr_cyc", verr_cyc, line_cyc[3] + 2);
    chk("vwide_unlocked", locked, 0);
    chk("vwide_frame_cnt", frame_cnt, 4);
    chk("vwide_herr_count", herr_n, 1);

    // hsync stuck low while in CHECK: one timeout at h_cnt 1023.
    for (int ln = 0; ln < 3; ln++) send_cols(ln, 0, HT, VS);
    for (int k = 0; k < 2000; k++) begin
      if (k == 1023 - HT) mark = cyc;
      tick(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    chk("timeout_herr_count", herr_n, 2);
    chk("timeout_herr_cyc", herr_cyc, mark + 2);
    send_frame(VS, -1);
    chk("timeout_search_herr", herr_n, 2);
    chk("timeout_relock1", locked, 0);
    send_frame(VS, -1);
    chk("timeout_relock2", locked, 1);
    chk("timeout_verr_count", verr_n, 1);

    // One-cycle reset in the middle of a locked frame.
    for (int ln = 0; ln < 8; ln++) send_cols(ln, 0, HT, VS);
    send_cols(8, 0, 12, VS);
    chk("prerst_locked", locked, 1);
    chk("prerst_pix_valid", pix_valid, 1);
    chk("prerst_frame_cnt", frame_cnt, 5);
    tick(1'b0, 1'b0, pix_of(8, 12), 1'b1);
    chk("postrst_pix_valid", pix_valid, 0);
    chk("postrst_pix_x", pix_x, 0);
    chk("postrst_pix_y", pix_y, 0);
    chk("postrst_pix_rgb", pix_rgb, 0);
    chk("postrst_locked", locked, 0);
    chk("postrst_frame_cnt", frame_cnt, 0);
    chk("postrst_pulses", {frame_done, h_err, v_err, rgb_err}, 0);
    send_cols(8, 13, HT, VS);
    for (int ln = 9; ln < VT; ln++) send_cols(ln, 0, HT, VS);
    chk("rst_frame_unlocked", locked, 0);
    send_frame(VS, -1);
    chk("rst_relock1", locked, 0);
    send_frame(VS, -1);
    chk("rst_relock2", locked, 1);
    chk("rst_relock2_frame_cnt", frame_cnt, 0);
    p0 = pix_total;
    send_frame(VS, -1);
    chk("rst_after_frame_cnt", frame_cnt, 1);
    chk("rst_after_pix_count", pix_total - p0, 288);
    chk("final_herr_count", herr_n, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
